// File: rtl/mul_accum_serializer.sv
// mul_accum_serializer
//   Sums COUNT consecutive unsigned products into an ACC_W-bit accumulator,
//   then emits the sum as a little-endian byte stream on a valid/ready port.
//   Products are refused while a sum is being sent, so frames never overlap.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous flush, drops any partial or in-flight frame
//   prod        product input, unsigned, PROD_W bits
//   prod_valid  prod is valid this cycle
//   prod_ready  block accepts prod this cycle
//   out_data    current output byte
//   out_valid   out_data is valid
//   out_ready   consumer accepts out_data
//   out_last    final (most significant) byte of the frame
//   overflow    frame sum carried out of ACC_W bits, valid with out_valid
//
// state   | meaning
// ST_ACC  | accepting products, summing into acc
// ST_OUT  | sending acc one byte per out_ready, LSB first

module mul_accum_serializer #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow
);

  localparam int BEATS  = ACC_W / 8;
  localparam int CNT_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ovf_q, ovf_d;

  logic [ACC_W:0]      sum;
  logic [7:0]          byte_sel;
  logic                beat_is_last;

  // One extra bit so the carry out of ACC_W is visible for the overflow flag.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  assign beat_is_last = (beat_q == BEAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;

    if (clear) begin
      // Flush wins over any product or output handshake in the same cycle.
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      beat_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (prod_valid) begin
            acc_d = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
              ovf_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              beat_d  = '0;
              state_d = ST_OUT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (beat_is_last) begin
              acc_d   = '0;
              ovf_d   = 1'b0;
              beat_d  = '0;
              state_d = ST_ACC;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_ACC;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_q == BEAT_W'(i)) begin
        byte_sel = acc_q[8*i +: 8];
      end
    end
  end

  // prod_ready is gated by rst_n so it drops the moment reset asserts.
  assign prod_ready = rst_n && (state_q == ST_ACC);
  assign out_valid  = (state_q == ST_OUT);
  assign out_last   = out_valid && beat_is_last;
  assign out_data   = out_valid ? byte_sel : 8'h00;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mul_accum_serializer.sv
module tb_mul_accum_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults (ACC_W=16, COUNT=4)
  logic       clear0 = 1'b0, prod_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [7:0] prod0 = '0;
  logic       prod_ready0, out_valid0, out_last0, overflow0;
  logic [7:0] out_data0;

  // dut1: ACC_W=8, COUNT=2
  logic       clear1 = 1'b0, prod_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [7:0] prod1 = '0;
  logic       prod_ready1, out_valid1, out_last1, overflow1;
  logic [7:0] out_data1;

  mul_accum_serializer #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0),
    .prod(prod0), .prod_valid(prod_valid0), .prod_ready(prod_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_last(out_last0), .overflow(overflow0)
  );

  mul_accum_serializer #(.PROD_W(8), .ACC_W(8), .COUNT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1),
    .prod(prod1), .prod_valid(prod_valid1), .prod_ready(prod_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .overflow(overflow1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of the frame's products, reduced mod 2^accw; overflow when
  // the true total reaches 2^accw (products are non-negative, so any partial
  // carry implies this and vice versa).
  task automatic model(input int unsigned prods[$], input int accw,
                       output logic [31:0] val, output logic ovf);
    longint unsigned total = 0;
    longint unsigned lim = 64'd1 << accw;
    foreach (prods[i]) total += prods[i];
    val = 32'(total % lim);
    ovf = (total >= lim);
  endtask

  // ---------- dut0 helpers ----------
  task automatic push0(input logic [7:0] p, input int k, input int gap);
    int t = 0;
    prod_valid0 = 1'b0;
    repeat (gap) begin
      step();
      check("idle_no_out", out_valid0, 0);
    end
    prod0 = p;
    prod_valid0 = 1'b1;
    while (!prod_ready0 && t < 50) begin step(); t++; end
    if (t >= 50) check("push0_timeout", 0, 1);
    step();
    prod_valid0 = 1'b0;
    check("latency_valid", out_valid0, (k == 3) ? 1 : 0);
  endtask

  task automatic collect0(input logic [31:0] val, input logic ovf, input int stall);
    int t;
    logic [31:0] v = val;
    for (int b = 0; b < 2; b++) begin
      t = 0;
      out_ready0 = 1'b0;
      while (!out_valid0 && t < 50) begin step(); t++; end
      if (t >= 50) check("collect0_timeout", 0, 1);
      for (int s = 0; s < stall; s++) begin
        check("hold_data", out_data0, v[8*b +: 8]);
        check("hold_valid", out_valid0, 1);
        check("hold_pready", prod_ready0, 0);
        check("hold_last", out_last0, (b == 1) ? 1 : 0);
        step();
      end
      check("byte", out_data0, v[8*b +: 8]);
      check("last", out_last0, (b == 1) ? 1 : 0);
      check("ovf", overflow0, ovf);
      check("pready_out", prod_ready0, 0);
      out_ready0 = 1'b1;
      step();
      out_ready0 = 1'b0;
    end
    check("frame_done_valid", out_valid0, 0);
    check("frame_done_pready", prod_ready0, 1);
  endtask

  task automatic frame0(input logic [31:0] ps, input int gap, input int stall);
    int unsigned q[$];
    logic [31:0] val;
    logic ovf;
    for (int i = 0; i < 4; i++) q.push_back(int'(ps[8*i +: 8]));
    model(q, 16, val, ovf);
    for (int i = 0; i < 4; i++) push0(ps[8*i +: 8], i, gap);
    collect0(val, ovf, stall);
  endtask

  // ---------- dut1 helpers ----------
  task automatic frame1(input logic [7:0] a, input logic [7:0] b, input int stall);
    int unsigned q[$];
    logic [31:0] val;
    logic ovf;
    int t = 0;
    q.push_back(int'(a));
    q.push_back(int'(b));
    model(q, 8, val, ovf);
    prod1 = a; prod_valid1 = 1'b1; step();
    check("d1_mid_valid", out_valid1, 0);
    prod1 = b; step();
    prod_valid1 = 1'b0;
    check("d1_valid", out_valid1, 1);
    out_ready1 = 1'b0;
    repeat (stall) begin
      check("d1_hold", out_data1, val[7:0]);
      step();
    end
    while (!out_valid1 && t < 50) begin step(); t++; end
    if (t >= 50) check("d1_timeout", 0, 1);
    check("d1_byte", out_data1, val[7:0]);
    check("d1_last", out_last1, 1);
    check("d1_ovf", overflow1, ovf);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("d1_done", out_valid1, 0);
  endtask

  initial begin
    logic [31:0] ps;
    // reset state, before any clock edge
    #2;
    check("rst_pready", prod_ready0, 0);
    check("rst_valid", out_valid0, 0);
    check("rst_data", out_data0, 0);
    check("rst_last", out_last0, 0);
    check("rst_ovf", overflow0, 0);
    #5 rst_n = 1'b1;
    step();
    check("post_rst_pready", prod_ready0, 1);

    // 225 x4, valid held, no stalls -> 0x84, 0x03
    frame0({8'd225, 8'd225, 8'd225, 8'd225}, 0, 0);
    // 1,2,3,4 with valid toggling
    frame0({8'd4, 8'd3, 8'd2, 8'd1}, 1, 0);
    // backpressure 5 cycles, 4x15
    frame0({8'd15, 8'd15, 8'd15, 8'd15}, 0, 5);

    // narrow accumulator: 200+100 overflows, then 1+1 clean
    frame1(8'd200, 8'd100, 0);
    frame1(8'd1, 8'd1, 2);

    // clear after byte 0 sent; product offered during clear is dropped
    for (int i = 0; i < 4; i++) push0(8'd225, i, 0);
    check("clr_b0", out_data0, 8'h84);
    out_ready0 = 1'b1; step(); out_ready0 = 1'b0;
    check("clr_b1_pending", out_data0, 8'h03);
    clear0 = 1'b1; prod0 = 8'd99; prod_valid0 = 1'b1;
    step();
    clear0 = 1'b0; prod_valid0 = 1'b0;
    check("clr_valid_drop", out_valid0, 0);
    check("clr_last_drop", out_last0, 0);
    check("clr_pready", prod_ready0, 1);
    frame0({8'd1, 8'd1, 8'd1, 8'd1}, 0, 0);

    // async reset mid-frame after 2 accepts
    push0(8'd100, 0, 0);
    push0(8'd50, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pready", prod_ready0, 0);
    check("arst_valid", out_valid0, 0);
    check("arst_ovf", overflow0, 0);
    #2 rst_n = 1'b1;
    step();
    frame0({8'd7, 8'd6, 8'd5, 8'd250}, 0, 1);

    // randomized frames against the model
    for (int f = 0; f < 20; f++) begin
      ps = $urandom;
      frame0(ps, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    for (int f = 0; f < 10; f++) begin
      frame1(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
